state_dumper: RTL and testbench

STATE_DUMPER -- requirements
Module: state_dumper

---
 rtl/state_dumper_pkg.sv | 27 ++
 rtl/state_dumper_edge_detect_fall.sv | 20 ++
 rtl/state_dumper.sv | 103 ++++++++++
 tb/tb_state_dumper.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_dumper_pkg.sv
// Shared types and constants for the state dumper: FSM encoding, default sizes
// and the tag layout used to mark register versus memory words.
package state_dumper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REGS  = 2'd1,
    MEMS  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int NUM_MEM  = 16;
  localparam int IDX_W    = 4;
  localparam int TAG_W    = 5;
  localparam int TAG_MEM  = 4;

  // Tag = index in the low bits, with the memory flag at TAG_MEM.
  function automatic logic [TAG_W-1:0] make_tag(input logic is_mem, input logic [IDX_W-1:0] idx);
    logic [TAG_W-1:0] tag;
    tag          = TAG_W'(idx);
    tag[TAG_MEM] = is_mem;
    return tag;
  endfunction

endpackage

// File: rtl/state_dumper_edge_detect_fall.sv
// Falling-edge detector: keeps the previous sample of sig in a register and
// flags the cycle where a 1 is followed by a 0.
module edge_detect_fall (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall
);

  logic sig_q;

  // Clearing to 0 means a line that is already low after reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign fall = sig_q & ~sig;

endmodule

// File: rtl/state_dumper.sv
// Streams the register file and then data memory out over a valid/ready port
// whenever a manual request or a falling edge of the processor run enable arrives.
module state_dumper #(
  parameter int NUM_REGS = state_dumper_pkg::NUM_REGS,
  parameter int NUM_MEM  = state_dumper_pkg::NUM_MEM,
  parameter int DATA_W   = state_dumper_pkg::DATA_W
) (
  input  logic              main_clk,
  input  logic              restart,
  input  logic              controller_enable,
  input  logic              dump_req,
  output logic [2:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [3:0]        mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [4:0]        dump_tag,
  output logic              dump_last,
  output logic              dump_busy,
  output logic              dump_done
);
  import state_dumper_pkg::*;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             enable_fall;
  logic             trigger;
  logic             load;

  edge_detect_fall u_enable_fall (
    .clk  (main_clk),
    .rst  (restart),
    .sig  (controller_enable),
    .fall (enable_fall)
  );

  assign trigger     = dump_req | enable_fall;
  assign load        = ~dump_valid | dump_ready;
  assign dump_busy   = (state != IDLE);
  assign reg_rd_addr = (state == REGS) ? idx[2:0] : 3'd0;
  assign mem_rd_addr = (state == MEMS) ? idx : 4'd0;

  // A load refills the output register whenever it is empty or being taken,
  // so the index only moves when a word actually changes hands.
  always_ff @(posedge main_clk) begin
    if (restart) begin
      state      <= IDLE;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_done  <= 1'b0;
      dump_data  <= '0;
      dump_tag   <= '0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state <= REGS;
            idx   <= '0;
          end
        end
        REGS: begin
          if (load) begin
            dump_data  <= reg_rd_data;
            dump_tag   <= make_tag(1'b0, idx);
            dump_valid <= 1'b1;
            if (idx == IDX_W'(NUM_REGS - 1)) begin
              state <= MEMS;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        MEMS: begin
          if (load) begin
            dump_data  <= mem_rd_data;
            dump_tag   <= make_tag(1'b1, idx);
            dump_valid <= 1'b1;
            idx        <= idx + 1'b1;
            if (idx == IDX_W'(NUM_MEM - 1)) begin
              dump_last <= 1'b1;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_done  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_dumper.sv
// Scoreboard bench for state_dumper: stimulus pushes the expected word stream,
// a negedge monitor pops and compares every handshake.
module tb_state_dumper;

  localparam int NR = 8;
  localparam int NM = 16;
  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    tag;
    logic          last;
  } word_t;

  logic          main_clk = 1'b0;
  logic          restart = 1'b1;
  logic          controller_enable = 1'b0;
  logic          dump_req = 1'b0;
  logic          dump_ready = 1'b1;
  logic [2:0]    reg_rd_addr;
  logic [3:0]    mem_rd_addr;
  logic [DW-1:0] reg_rd_data;
  logic [DW-1:0] mem_rd_data;
  logic          dump_valid;
  logic [DW-1:0] dump_data;
  logic [4:0]    dump_tag;
  logic          dump_last;
  logic          dump_busy;
  logic          dump_done;

  logic [DW-1:0] reg_file [NR];
  logic [DW-1:0] mem_file [NM];

  word_t exp_q [$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  int    rcnt = 0;
  int    hs_count = 0;
  int    done_count = 0;
  int    exp_done = 0;
  int    first_hs_cyc = 0;
  int    last_span = 0;
  int    trig_cyc = 0;
  bit    done_due = 1'b0;
  bit    stalled = 1'b0;
  logic [14:0] held = '0;
  word_t mon_w;

  state_dumper dut (
    .main_clk          (main_clk),
    .restart           (restart),
    .controller_enable (controller_enable),
    .dump_req          (dump_req),
    .reg_rd_addr       (reg_rd_addr),
    .reg_rd_data       (reg_rd_data),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .dump_valid        (dump_valid),
    .dump_ready        (dump_ready),
    .dump_data         (dump_data),
    .dump_tag          (dump_tag),
    .dump_last         (dump_last),
    .dump_busy         (dump_busy),
    .dump_done         (dump_done)
  );

  assign reg_rd_data = reg_file[reg_rd_addr];
  assign mem_rd_data = mem_file[mem_rd_addr];

  always #5 main_clk = ~main_clk;

  always @(posedge main_clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  // Consumer backpressure: steady, fixed 1,0,0 pattern, or random.
  always @(posedge main_clk) begin
    #1;
    case (ready_mode)
      0:       dump_ready = 1'b1;
      1:       dump_ready = (rcnt % 3 == 0);
      default: dump_ready = 1'($urandom_range(0, 1));
    endcase
    rcnt++;
  end

  // Monitor: done pulse, stall stability, and in-order word comparison.
  always @(negedge main_clk) begin
    if (restart) begin
      stalled  = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due || dump_done) begin
        checkOutput("done_pulse", 32'(dump_done), 32'(done_due));
        if (dump_done) begin
          done_count++;
          checkOutput("busy_at_done", 32'(dump_busy), 32'd0);
        end
        done_due = 1'b0;
      end
      if (stalled)
        checkOutput("stall_hold", 32'({dump_valid, dump_data, dump_tag, dump_last}), 32'({1'b1, held[13:0]}));
      if (dump_valid && dump_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checkOutput("queue_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_w = exp_q.pop_front();
          checkOutput("word", 32'({dump_data, dump_tag, dump_last}), 32'(mon_w));
          if (mon_w.tag == 5'd0) first_hs_cyc = cyc;
          if (mon_w.last) begin
            done_due  = 1'b1;
            last_span = cyc - first_hs_cyc;
          end
        end
      end
      stalled = dump_valid && !dump_ready;
      held    = {dump_valid, dump_data, dump_tag, dump_last};
    end
  end

  task automatic applyStimulus(input logic req, input logic en);
    @(posedge main_clk);
    #1;
    dump_req          = req;
    controller_enable = en;
  endtask

  // Reference model: every register in order, then every memory word, last flag on the final one.
  task automatic pushDump();
    word_t w;
    for (int i = 0; i < NR; i++) begin
      w.data = reg_file[i]; w.tag = 5'(i); w.last = 1'b0;
      exp_q.push_back(w);
    end
    for (int j = 0; j < NM; j++) begin
      w.data = mem_file[j]; w.tag = 5'(16 + j); w.last = (j == NM - 1);
      exp_q.push_back(w);
    end
    exp_done++;
    trig_cyc = cyc;
  endtask

  task automatic randomizeState();
    for (int i = 0; i < NR; i++) reg_file[i] = DW'($urandom);
    for (int j = 0; j < NM; j++) mem_file[j] = DW'($urandom);
  endtask

  task automatic doReset();
    @(posedge main_clk);
    #1;
    restart  = 1'b1;
    dump_req = 1'b0;
    @(posedge main_clk);
    #1;
    restart = 1'b0;
    exp_q.delete();
    @(negedge main_clk);
    checkOutput("reset_outputs",
                32'({dump_valid, dump_last, dump_busy, dump_done, dump_data, dump_tag, reg_rd_addr, mem_rd_addr}),
                32'd0);
  endtask

  task automatic waitIdle();
    int t = 0;
    while ((exp_q.size() != 0 || done_count < exp_done) && t < 3000) begin
      @(negedge main_clk);
      t++;
    end
    checkOutput("dump_complete", 32'(done_count), 32'(exp_done));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitHandshakes(input int n);
    int base = hs_count;
    int t = 0;
    while (hs_count < base + n && t < 2000) begin
      @(posedge main_clk);
      t++;
    end
    checkOutput("handshakes_reached", 32'(hs_count >= base + n), 32'd1);
  endtask

  task automatic checkQuiet(input string name);
    repeat (30) @(posedge main_clk);
    @(negedge main_clk);
    checkOutput(name, 32'({dump_busy, dump_valid}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) reg_file[i] = '0;
    for (int j = 0; j < NM; j++) mem_file[j] = '0;
    repeat (3) @(posedge main_clk);
    doReset();

    // Fixed pattern, steady ready, triggered by run enable dropping.
    for (int i = 0; i < NR; i++) reg_file[i] = DW'(i + 1);
    for (int j = 0; j < NM; j++) mem_file[j] = DW'(8'hA0 + j);
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(posedge main_clk);
    applyStimulus(1'b0, 1'b0);
    pushDump();
    waitIdle();
    checkOutput("first_word_latency", 32'(first_hs_cyc - trig_cyc), 32'd2);
    checkOutput("back_to_back_span", 32'(last_span), 32'd23);

    // Manual request with ready pattern 1,0,0 repeating.
    $display("[TB] dump_req with stalled consumer");
    randomizeState();
    ready_mode = 1;
    applyStimulus(1'b1, 1'b0);
    pushDump();
    applyStimulus(1'b0, 1'b0);
    waitIdle();

    // Second request and an enable fall arriving mid-dump must be ignored.
    $display("[TB] triggers during a dump");
    randomizeState();
    ready_mode = 2;
    applyStimulus(1'b1, 1'b0);
    pushDump();
    applyStimulus(1'b0, 1'b1);
    waitHandshakes(5);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitIdle();
    checkQuiet("no_extra_dump_mid");

    // Request and enable fall in the same cycle start a single dump.
    $display("[TB] simultaneous triggers");
    applyStimulus(1'b0, 1'b1);
    repeat (2) @(posedge main_clk);
    randomizeState();
    applyStimulus(1'b1, 1'b0);
    pushDump();
    applyStimulus(1'b0, 1'b0);
    waitIdle();
    checkQuiet("no_extra_dump_simul");

    // Restart after the 10th handshake aborts, then a fresh dump starts from r0.
    $display("[TB] restart mid-dump");
    randomizeState();
    ready_mode = 0;
    applyStimulus(1'b1, 1'b0);
    pushDump();
    applyStimulus(1'b0, 1'b0);
    waitHandshakes(10);
    #1;
    restart = 1'b1;
    @(posedge main_clk);
    #1;
    restart = 1'b0;
    exp_q.delete();
    exp_done--;
    @(negedge main_clk);
    checkOutput("abort_outputs",
                32'({dump_valid, dump_last, dump_busy, dump_done, dump_data, dump_tag, reg_rd_addr, mem_rd_addr}),
                32'd0);
    repeat (5) @(posedge main_clk);
    checkOutput("abort_no_done", 32'(done_count), 32'(exp_done));
    randomizeState();
    applyStimulus(1'b1, 1'b0);
    pushDump();
    applyStimulus(1'b0, 1'b0);
    waitIdle();

    // Reset with enable low: the rise must not dump, the following fall dumps once.
    $display("[TB] enable rise after restart");
    doReset();
    applyStimulus(1'b0, 1'b1);
    checkQuiet("no_dump_on_rise");
    randomizeState();
    applyStimulus(1'b0, 1'b0);
    pushDump();
    waitIdle();
    checkQuiet("single_dump_on_fall");

    // Random mix of trigger kinds and backpressure.
    $display("[TB] random dumps");
    for (int k = 0; k < 4; k++) begin
      int kind = $urandom_range(0, 2);
      randomizeState();
      ready_mode = $urandom_range(0, 2);
      if (kind != 0) begin
        applyStimulus(1'b0, 1'b1);
        repeat (2) @(posedge main_clk);
      end
      applyStimulus(kind != 1, 1'b0);
      pushDump();
      applyStimulus(1'b0, 1'b0);
      waitIdle();
    end

    repeat (5) @(posedge main_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
